// File: rtl/stopwatch_bcd_if.sv
// Pushbutton inputs and BCD display outputs of the MM:SS stopwatch.
// The board-side driver uses master; the stopwatch core uses slave.
interface stopwatch_bcd_if;
  logic       key_start;
  logic       key_clear;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       wrap;

  modport master (
    output key_start, key_clear,
    input  min_tens, min_ones, sec_tens, sec_ones, running, wrap
  );

  modport slave (
    input  key_start, key_clear,
    output min_tens, min_ones, sec_tens, sec_ones, running, wrap
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// Four-digit MM:SS stopwatch: synchronised active-low keys, IDLE/RUN/PAUSE FSM,
// per-second prescaler and a BCD digit cascade that rolls 59:59 -> 00:00.
module stopwatch_bcd #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic            clock,
  input  logic            reset,
  stopwatch_bcd_if.slave  io
);
  localparam int unsigned   PW   = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]    press;
  logic          start_press, clear_press;
  logic          advance, tick;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic          running_q, running_d, wrap_q, wrap_d;

  // Bit 0 carries key_start, bit 1 carries key_clear through the synchroniser.
  always_comb begin
    s1_d        = {io.key_clear, io.key_start};
    s2_d        = s1_q;
    s3_d        = s2_q;
    press       = ~s2_q & s3_q;
    start_press = press[0];
    clear_press = press[1];
  end

  always_comb begin
    state_d = state_q;
    if (clear_press) begin
      state_d = IDLE;
    end else if (start_press) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Only advance when staying in RUN, so a pause on terminal count holds TERM.
  always_comb begin
    advance    = (state_q == RUN) && (state_d == RUN);
    tick       = advance && (presc_q == TERM);
    presc_d    = presc_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    wrap_d     = 1'b0;
    running_d  = (state_d == RUN);

    if (clear_press || state_q == IDLE) begin
      presc_d = '0;
    end else if (advance) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (clear_press) begin
      min_tens_d = '0;
      min_ones_d = '0;
      sec_tens_d = '0;
      sec_ones_d = '0;
    end else if (tick) begin
      if (sec_ones_q != 4'd9) begin
        sec_ones_d = sec_ones_q + 4'd1;
      end else begin
        sec_ones_d = '0;
        if (sec_tens_q != 4'd5) begin
          sec_tens_d = sec_tens_q + 4'd1;
        end else begin
          sec_tens_d = '0;
          if (min_ones_q != 4'd9) begin
            min_ones_d = min_ones_q + 4'd1;
          end else begin
            min_ones_d = '0;
            if (min_tens_q != 4'd5) begin
              min_tens_d = min_tens_q + 4'd1;
            end else begin
              min_tens_d = '0;
              wrap_d     = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      s1_q       <= '1;
      s2_q       <= '1;
      s3_q       <= '1;
      presc_q    <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      presc_q    <= presc_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
    end
  end

  assign io.min_tens = min_tens_q;
  assign io.min_ones = min_ones_q;
  assign io.sec_tens = sec_tens_q;
  assign io.sec_ones = sec_ones_q;
  assign io.running  = running_q;
  assign io.wrap     = wrap_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd at TICKS_PER_SEC = 4: hand-derived vector table,
// async reset check, then random and full-hour runs against a seconds-count model.
module tb_stopwatch_bcd;
  localparam int T = 4;

  logic clock;
  logic reset;
  stopwatch_bcd_if sw_if ();

  stopwatch_bcd #(.TICKS_PER_SEC(T)) dut (
    .clock (clock),
    .reset (reset),
    .io    (sw_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Observed word: {mm:ss as four BCD nibbles, running, wrap}
  function automatic logic [17:0] dut_obs();
    return {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones,
            sw_if.running, sw_if.wrap};
  endfunction

  // Reference model: elapsed seconds as an integer, press detection from key sample history.
  int       m_secs, m_presc;
  bit       m_run, m_started, m_wrap;
  bit [3:0] hs, hc;

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_run = 0; m_started = 0; m_wrap = 0;
    hs = '1; hc = '1;
  endtask

  task automatic model_step(input logic ks, input logic kc);
    bit sp, cp;
    hs = {hs[2:0], ks};
    hc = {hc[2:0], kc};
    sp = !hs[2] && hs[3];
    cp = !hc[2] && hc[3];
    m_wrap = 0;
    if (cp) begin
      m_run = 0; m_started = 0; m_secs = 0; m_presc = 0;
    end else begin
      if (m_run && !sp) begin
        if (m_presc == T - 1) begin
          m_presc = 0;
          m_secs  = (m_secs + 1) % 3600;
          m_wrap  = (m_secs == 0);
        end else m_presc++;
      end
      if (sp) begin
        if (m_run) m_run = 0;
        else begin
          if (!m_started) begin m_presc = 0; m_started = 1; end
          m_run = 1;
        end
      end
    end
  endtask

  function automatic logic [17:0] model_obs();
    int mins = m_secs / 60;
    int secs = m_secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), m_run, m_wrap};
  endfunction

  typedef struct {
    logic        ks;
    logic        kc;
    int unsigned n;
    logic [15:0] disp;
    logic        run;
    logic        wrap;
  } vec_t;

  vec_t vq[$];
  logic ks_r, kc_r;
  int   dut_wraps, prev_secs;
  logic legal;

  initial begin
    vq.push_back('{1'b1, 1'b1,  2, 16'h0000, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1,  1, 16'h0000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0000, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0000, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  4, 16'h0001, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 36, 16'h0010, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0,  1, 16'h0010, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0010, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0000, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 50, 16'h0011, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0012, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0012, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1,  1, 16'h0012, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  2, 16'h0012, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 20, 16'h0012, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1,  1, 16'h0012, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0012, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0012, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0013, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0013, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0,  1, 16'h0013, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0013, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b1,  1, 16'h0000, 1'b0, 1'b0});

    // Reset and release
    reset = 1'b0;
    sw_if.key_start = 1'b1;
    sw_if.key_clear = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1 check("reset_state", 32'(dut_obs()), 32'h0);
    @(posedge clock);
    #1;

    foreach (vq[i]) begin
      sw_if.key_start = vq[i].ks;
      sw_if.key_clear = vq[i].kc;
      repeat (vq[i].n) @(posedge clock);
      #1 check($sformatf("vec%0d", i), 32'(dut_obs()),
               32'({vq[i].disp, vq[i].run, vq[i].wrap}));
    end

    // Asynchronous reset in the middle of a count
    sw_if.key_start = 1'b0;
    @(posedge clock);
    #1 sw_if.key_start = 1'b1;
    repeat (12) @(posedge clock);
    #1 check("pre_async_reset", 32'(dut_obs()), 32'({16'h0002, 1'b1, 1'b0}));
    #2 reset = 1'b0;
    #1 check("async_reset", 32'(dut_obs()), 32'h0);
    #2 reset = 1'b1;
    model_reset();

    // Random key activity against the model
    ks_r = 1'b1;
    kc_r = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      model_step(ks_r, kc_r);
      #1 check("rand", 32'(dut_obs()), 32'(model_obs()));
      if ($urandom_range(0, 29) == 0)  ks_r = ~ks_r;
      if ($urandom_range(0, 149) == 0) kc_r = ~kc_r;
      sw_if.key_start = ks_r;
      sw_if.key_clear = kc_r;
    end

    // Full hour: carry chain, BCD legality and a single wrap pulse
    #2 reset = 1'b0;
    sw_if.key_start = 1'b1;
    sw_if.key_clear = 1'b1;
    #2 reset = 1'b1;
    model_reset();
    dut_wraps = 0;
    sw_if.key_start = 1'b0;
    for (int c = 0; c < 4 * 3600 + 20; c++) begin
      @(posedge clock);
      prev_secs = m_secs;
      model_step(sw_if.key_start, sw_if.key_clear);
      #1 check("hour", 32'(dut_obs()), 32'(model_obs()));
      legal = (sw_if.sec_ones <= 4'd9) && (sw_if.sec_tens <= 4'd5) &&
              (sw_if.min_ones <= 4'd9) && (sw_if.min_tens <= 4'd5);
      if (!legal) check("bcd_legal", 32'(legal), 32'd1);
      if (prev_secs == 599 && m_secs == 600)
        check("carry_10_00", 32'(dut_obs()), 32'({16'h1000, 1'b1, 1'b0}));
      if (sw_if.wrap) dut_wraps++;
      sw_if.key_start = 1'b1;
    end
    check("wrap_count", 32'(dut_wraps), 32'd1);
    check("running_after_wrap", 32'(sw_if.running), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
